// File: rtl/apb_gpio_ng_if.sv
// APB slave bus bundle for apb_gpio_ng. PREADY and PSLVERR are driven by the slave.
interface apb_gpio_ng_if #(
  parameter int unsigned APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_ng.sv
// APB GPIO controller: atomic output ops, per-pin debounce, sticky W1C interrupt status,
// and a power-event wake request derived from the filtered inputs.
module apb_gpio_ng #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NUM_GPIO       = 32,
  parameter int unsigned DEBOUNCE_W     = 8
) (
  input  logic                HCLK,
  input  logic                HRESET,
  apb_gpio_ng_if.slave        apb,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_dir,
  output logic                power_event,
  output logic                interrupt
);

  localparam logic [3:0] RegDir       = 4'h0;
  localparam logic [3:0] RegIn        = 4'h1;
  localparam logic [3:0] RegOut       = 4'h2;
  localparam logic [3:0] RegOutSet    = 4'h3;
  localparam logic [3:0] RegOutClr    = 4'h4;
  localparam logic [3:0] RegOutTgl    = 4'h5;
  localparam logic [3:0] RegIntEn     = 4'h6;
  localparam logic [3:0] RegIntType0  = 4'h7;
  localparam logic [3:0] RegIntType1  = 4'h8;
  localparam logic [3:0] RegIntStatus = 4'h9;
  localparam logic [3:0] RegDbEn      = 4'hA;
  localparam logic [3:0] RegDbCnt     = 4'hB;
  localparam logic [3:0] RegPwrEvt    = 4'hC;

  typedef logic [NUM_GPIO-1:0] pins_t;

  pins_t dir_q, out_q, inten_q, type0_q, type1_q, status_q, dben_q, pwrevt_q;
  pins_t sync0_q, sync1_q, filt_q, filt_dly_q;
  logic [DEBOUNCE_W-1:0] dbcnt_q;
  logic [DEBOUNCE_W-1:0] cnt_q [NUM_GPIO];
  logic [DEBOUNCE_W-1:0] cnt_d [NUM_GPIO];

  pins_t filt_d, out_d, status_d, match, wdata, w1c;
  logic [3:0]  addr;
  logic        access, wr_en;
  logic [31:0] rdata;

  logic [APB_ADDR_WIDTH-1:0] unused_paddr;
  logic [31:0]               unused_pwdata;
  assign unused_paddr  = apb.PADDR;
  assign unused_pwdata = apb.PWDATA;

  assign addr   = apb.PADDR[5:2];
  assign access = apb.PSEL & apb.PENABLE;
  assign wr_en  = access & apb.PWRITE;
  assign wdata  = apb.PWDATA[NUM_GPIO-1:0];

  // Debounce: filt follows sync1 only after DBCNT+1 consecutive mismatching cycles.
  always_comb begin
    for (int i = 0; i < NUM_GPIO; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = cnt_q[i];
      if (!dben_q[i]) begin
        filt_d[i] = sync1_q[i];
      end else if (sync1_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < dbcnt_q) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        filt_d[i] = sync1_q[i];
        cnt_d[i]  = '0;
      end
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_GPIO; i++) begin
      unique case ({type1_q[i], type0_q[i]})
        2'b00: match[i] = filt_q[i];
        2'b01: match[i] = ~filt_q[i];
        2'b10: match[i] = filt_q[i] & ~filt_dly_q[i];
        2'b11: match[i] = ~filt_q[i] & filt_dly_q[i];
      endcase
    end
  end

  // OR-ing the new events after the clear lets a same-cycle set win.
  always_comb begin
    w1c      = (wr_en && addr == RegIntStatus) ? wdata : '0;
    status_d = (status_q & ~w1c) | (inten_q & match);
  end

  always_comb begin
    out_d = out_q;
    if (wr_en) begin
      case (addr)
        RegOut:    out_d = wdata;
        RegOutSet: out_d = out_q | wdata;
        RegOutClr: out_d = out_q & ~wdata;
        RegOutTgl: out_d = out_q ^ wdata;
        default:   out_d = out_q;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dir_q      <= '0;
      out_q      <= '0;
      inten_q    <= '0;
      type0_q    <= '0;
      type1_q    <= '0;
      status_q   <= '0;
      dben_q     <= '0;
      pwrevt_q   <= '0;
      dbcnt_q    <= '0;
      sync0_q    <= '0;
      sync1_q    <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      cnt_q      <= '{default: '0};
    end else begin
      sync0_q    <= gpio_in;
      sync1_q    <= sync0_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      status_q   <= status_d;
      if (wr_en) begin
        case (addr)
          RegDir:      dir_q    <= wdata;
          RegIntEn:    inten_q  <= wdata;
          RegIntType0: type0_q  <= wdata;
          RegIntType1: type1_q  <= wdata;
          RegDbEn:     dben_q   <= wdata;
          RegDbCnt:    dbcnt_q  <= apb.PWDATA[DEBOUNCE_W-1:0];
          RegPwrEvt:   pwrevt_q <= wdata;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      RegDir:       rdata = 32'(dir_q);
      RegIn:        rdata = 32'(filt_q);
      RegOut:       rdata = 32'(out_q);
      RegIntEn:     rdata = 32'(inten_q);
      RegIntType0:  rdata = 32'(type0_q);
      RegIntType1:  rdata = 32'(type1_q);
      RegIntStatus: rdata = 32'(status_q);
      RegDbEn:      rdata = 32'(dben_q);
      RegDbCnt:     rdata = 32'(dbcnt_q);
      RegPwrEvt:    rdata = 32'(pwrevt_q);
      default:      rdata = '0;
    endcase
  end

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & (addr >= 4'hD);

  assign interrupt   = |(status_q & inten_q);
  assign power_event = |(pwrevt_q & filt_q);
  assign gpio_out    = out_q;
  assign gpio_dir    = dir_q;

endmodule

// File: doc/apb_gpio_ng.md
Name: apb_gpio_ng

Overview:
Next-generation APB GPIO controller with a configurable pin count.
- Adds atomic set/clear/toggle output registers and per-pin programmable input debounce.
- Interrupt status is sticky and write-1-to-clear; the controller raises a level interrupt while any enabled status bit is set.
- Sits on the peripheral APB bus alongside the existing GPIO block. Pads and the power manager connect to it directly.

Parameters:
- APB_ADDR_WIDTH, 12, APB address width (4 KB slave).
- NUM_GPIO, 32, number of pins, legal range 1..32.
- DEBOUNCE_W, 8, width of each per-pin debounce counter and of the DBCNT threshold.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  reset, synchronous, active-high.
- PADDR  in  APB_ADDR_WIDTH  APB address; only PADDR[5:2] is decoded.
- PWDATA  in  32  write data.
- PWRITE  in  1  1 = write.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PRDATA  out  32  read data.
- PREADY  out  1  constant 1.
- PSLVERR  out  1  error response.
- gpio_in  in  NUM_GPIO  asynchronous pad inputs.
- gpio_out  out  NUM_GPIO  output values.
- gpio_dir  out  NUM_GPIO  1 = output enable.
- power_event  out  1  wake request.
- interrupt  out  1  level interrupt.

Behaviour:
- Reset: HRESET is sampled on HCLK; synchronous, active-high. It clears every register, synchronizer, filter, counter and status bit to 0. gpio_out, gpio_dir, interrupt, power_event and PRDATA (for idle address 0) all read 0. Reset asserted mid-operation aborts debounce counts and discards pending status.
- Access: a write commits on PSEL & PENABLE & PWRITE. There are no wait states.
- PSLVERR: 1 during PSEL & PENABLE when PADDR[5:2] is 0xD–0xF, otherwise 0. Unmapped writes are ignored and unmapped reads return 0.
- Register map (offset, name):
  - 0x00 DIR (RW).
  - 0x04 IN (RO, filtered input).
  - 0x08 OUT (RW).
  - 0x0C OUTSET (WO): OUT |= data.
  - 0x10 OUTCLR (WO): OUT &= ~data.
  - 0x14 OUTTGL (WO): OUT ^= data.
  - 0x18 INTEN (RW).
  - 0x1C INTTYPE0 (RW).
  - 0x20 INTTYPE1 (RW).
  - 0x24 INTSTATUS (RW1C).
  - 0x28 DBEN (RW).
  - 0x2C DBCNT (RW, bits [DEBOUNCE_W-1:0]).
  - 0x30 PWREVT (RW mask).
- Read/write rules: WO registers read 0. Writes to IN are ignored. Bits at or above NUM_GPIO (and above DEBOUNCE_W in DBCNT) read 0 and ignore writes. PRDATA is combinational from PADDR[5:2].
- Input path: gpio_in → sync0 → sync1 → filt (per pin) → filt_d.
  - DBEN[i] = 0: filt[i] <= sync1[i]. A pad change is visible in IN 3 cycles after it is sampled.
  - DBEN[i] = 1: per-pin counter cnt[i].
    - sync1 == filt: cnt <= 0.
    - Mismatch with cnt < DBCNT: cnt++.
    - Mismatch with cnt == DBCNT: filt <= sync1 and cnt <= 0.
    - A change therefore needs DBCNT+1 consecutive mismatching cycles; DBCNT = 0 behaves like debounce off.
    - A glitch shorter than that resets the count and never reaches filt.
  - Changing DBEN or DBCNT takes effect the next cycle; counters are not cleared by that write.
- Interrupt type per pin, {INTTYPE1, INTTYPE0}:
  - 00: level high, filt = 1.
  - 01: level low, filt = 0.
  - 10: rising edge, filt & ~filt_d.
  - 11: falling edge, ~filt & filt_d.
- Status:
  - event[i] = INTEN[i] & type-match[i]. The next edge sets STATUS[i] <= 1.
  - A W1C write clears the bits written as 1.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - Level types re-set status every cycle the level holds.
  - Clearing INTEN does not clear STATUS.
- interrupt = |(STATUS & INTEN), combinational from registers. It rises in the same cycle STATUS updates: with debounce off, 4 edges after a rising edge is sampled by sync0.
- power_event = |(PWREVT & filt), combinational.
- gpio_out = OUT and gpio_dir = DIR, driven directly from the registers.

Test Plan:
- Reset/map: assert HRESET for 2 cycles → every register reads 0. Write 0xFFFFFFFF to OUT with NUM_GPIO = 20 → reads 0x000FFFFF. Read 0x34 → PSLVERR = 1, PRDATA = 0.
- Atomic ops: OUT = 0x00F0, then OUTSET 0x000F → 0x00FF, then OUTCLR 0x0081 → 0x007E, then OUTTGL 0xFFFF → 0xFF81. OUTSET reads 0.
- Rising edge: INTEN[3] = 1, type 10, DBEN = 0; raise gpio_in[3] → STATUS = 0x8 and interrupt = 1 on the 4th edge. W1C 0x8 → interrupt = 0 the next cycle, with no re-trigger while the pin stays high.
- Debounce: DBEN[0] = 1, DBCNT = 5. A 5-cycle pulse on gpio_in[0] → IN[0] stays 0 and no interrupt. A 6-cycle hold → IN[0] = 1 exactly 6 cycles after sync1 changes.
- Level + collision: type 00 on pin 7 with the pin held high; issue W1C 0x80 → STATUS[7] reads 1 again the next cycle, since set wins. Drive the pin low then W1C → STATUS = 0 and interrupt = 0.
- Power event: PWREVT = 0x5; drive gpio_in[2] high → power_event = 1 about 3 cycles later. Drive gpio_in[1] high with pin 2 low → power_event = 0.
